// File: rtl/core_seq_pkg.sv
// Shared NPU definitions for the tile sequencer: state encoding,
// legal configuration ranges and the configuration range check.
package core_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  localparam int K_MAX      = 3;
  localparam int IC_MAX     = 512;
  localparam int TILE_MAX   = 32;
  localparam int OC_MAX     = 64;
  localparam int STRIDE_MAX = 2;

  // Kernel is 1 or K_MAX; every other field is a 1-based count up to its max.
  function automatic logic cfg_legal(input int k, input int total_ic,
                                     input int img_h, input int img_w,
                                     input int oc, input int stride);
    return (k == 1 || k == K_MAX)
        && (total_ic >= 1) && (total_ic <= IC_MAX)
        && (img_h >= 1) && (img_h <= TILE_MAX)
        && (img_w >= 1) && (img_w <= TILE_MAX)
        && (oc >= 1) && (oc <= OC_MAX)
        && (stride >= 1) && (stride <= STRIDE_MAX);
  endfunction

endpackage

// File: rtl/core_seq.sv
// Tile sequencer: splits the input channels of one tile into passes of
// IC_PER_PASS channels, and for each pass handshakes the row-mem loader and
// the PE array, then drains the partial sums once after the last pass.
module core_seq
  import core_seq_pkg::*;
#(
  parameter int IC_PER_PASS = 4,
  parameter int ICW         = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           core_start,
  input  logic [2:0]     K,
  input  logic [ICW-1:0] TOTAL_IC,
  input  logic [5:0]     IMG_H,
  input  logic [5:0]     IMG_W,
  input  logic [7:0]     OC,
  input  logic [2:0]     STRIDE,
  output logic           busy,
  output logic           core_done,
  output logic           cfg_err,
  output logic           ld_start,
  input  logic           ld_done,
  output logic [ICW-1:0] pass_ic_base,
  output logic [ICW-1:0] pass_ic_cnt,
  output logic           pe_start,
  input  logic           pe_done,
  output logic           pe_accum,
  output logic           drain_start,
  input  logic           drain_done
);

  localparam logic [ICW-1:0] IPP_W = ICW'(IC_PER_PASS);

  typedef struct packed {
    logic [2:0]     k;
    logic [ICW-1:0] total_ic;
    logic [5:0]     img_h;
    logic [5:0]     img_w;
    logic [7:0]     oc;
    logic [2:0]     stride;
  } cfg_t;

  state_t         state;
  cfg_t           cfg_q;
  cfg_t           cfg_in;
  cfg_t           cfg_next;
  logic           start_take;
  logic           cfg_ok;
  logic [ICW:0]   next_base_ext;
  logic           more_passes;
  logic [ICW-1:0] next_base;

  // Channels in the pass starting at base; base is always below total here.
  function automatic logic [ICW-1:0] pass_cnt(input logic [ICW-1:0] total,
                                              input logic [ICW-1:0] base);
    logic [ICW-1:0] rem;
    rem = total - base;
    return (rem > IPP_W) ? IPP_W : rem;
  endfunction

  // Config selection, legality and next-pass arithmetic (one extra bit so
  // base + IC_PER_PASS cannot wrap near the top of the ICW range).
  always_comb begin
    // NOTE: every signal of this block is assigned on every path, so no latch is inferred.
    cfg_in        = '{k: K, total_ic: TOTAL_IC, img_h: IMG_H, img_w: IMG_W,
                      oc: OC, stride: STRIDE};
    start_take    = (state == ST_IDLE) && core_start;
    cfg_next      = start_take ? cfg_in : cfg_q;
    cfg_ok        = cfg_legal(int'(cfg_next.k), int'(cfg_next.total_ic),
                              int'(cfg_next.img_h), int'(cfg_next.img_w),
                              int'(cfg_next.oc), int'(cfg_next.stride));
    next_base_ext = {1'b0, pass_ic_base} + {1'b0, IPP_W};
    more_passes   = next_base_ext < {1'b0, cfg_q.total_ic};
    next_base     = next_base_ext[ICW-1:0];
  end

  // Sequencer FSM with registered handshake pulses; a done input is never
  // accepted in the cycle its own start pulse is high.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state        <= ST_IDLE;
      cfg_q        <= '0;
      busy         <= 1'b0;
      core_done    <= 1'b0;
      cfg_err      <= 1'b0;
      ld_start     <= 1'b0;
      pe_start     <= 1'b0;
      drain_start  <= 1'b0;
      pe_accum     <= 1'b0;
      pass_ic_base <= '0;
      pass_ic_cnt  <= '0;
    end else begin
      core_done   <= 1'b0;
      cfg_err     <= 1'b0;
      ld_start    <= 1'b0;
      pe_start    <= 1'b0;
      drain_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (core_start) begin
            cfg_q <= cfg_in;
            if (cfg_ok) begin
              state        <= ST_LOAD;
              busy         <= 1'b1;
              ld_start     <= 1'b1;
              pass_ic_base <= '0;
              pass_ic_cnt  <= pass_cnt(cfg_in.total_ic, '0);
              pe_accum     <= 1'b0;
            end else begin
              cfg_err   <= 1'b1;
              core_done <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (ld_done && !ld_start) begin
            state    <= ST_COMPUTE;
            pe_start <= 1'b1;
          end
        end
        ST_COMPUTE: begin
          if (pe_done && !pe_start) begin
            if (more_passes) begin
              state        <= ST_LOAD;
              ld_start     <= 1'b1;
              pass_ic_base <= next_base;
              pass_ic_cnt  <= pass_cnt(cfg_q.total_ic, next_base);
              pe_accum     <= 1'b1;
            end else begin
              state       <= ST_DRAIN;
              drain_start <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_done && !drain_start) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            core_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_seq.sv
// Scoreboard bench for core_seq: stimulus pushes the expected pulse events,
// a monitor pops and compares them whenever the DUT raises any pulse output,
// and a responder answers ld/pe/drain starts one cycle later.
module tb_core_seq;

  logic       clk;
  logic       reset;
  logic       core_start;
  logic [2:0] K;
  logic [9:0] TOTAL_IC;
  logic [5:0] IMG_H;
  logic [5:0] IMG_W;
  logic [7:0] OC;
  logic [2:0] STRIDE;
  logic       busy;
  logic       core_done;
  logic       cfg_err;
  logic       ld_start;
  logic       ld_done;
  logic [9:0] pass_ic_base;
  logic [9:0] pass_ic_cnt;
  logic       pe_start;
  logic       pe_done;
  logic       pe_accum;
  logic       drain_start;
  logic       drain_done;

  core_seq #(.IC_PER_PASS(4), .ICW(10)) dut (
    .clk(clk), .reset(reset), .core_start(core_start),
    .K(K), .TOTAL_IC(TOTAL_IC), .IMG_H(IMG_H), .IMG_W(IMG_W), .OC(OC),
    .STRIDE(STRIDE), .busy(busy), .core_done(core_done), .cfg_err(cfg_err),
    .ld_start(ld_start), .ld_done(ld_done), .pass_ic_base(pass_ic_base),
    .pass_ic_cnt(pass_ic_cnt), .pe_start(pe_start), .pe_done(pe_done),
    .pe_accum(pe_accum), .drain_start(drain_start), .drain_done(drain_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse vector order: {ld_start, pe_start, drain_start, core_done, cfg_err}
  localparam logic [4:0] V_LD    = 5'b10000;
  localparam logic [4:0] V_PE    = 5'b01000;
  localparam logic [4:0] V_DRAIN = 5'b00100;
  localparam logic [4:0] V_DONE  = 5'b00010;
  localparam logic [4:0] V_ERR   = 5'b00011;

  typedef struct {
    logic [4:0] vec;
    logic       chk_pass;
    logic [9:0] base;
    logic [9:0] cnt;
    logic       accum;
    logic       busy;
    int         gap;
  } ev_t;

  ev_t exp_q[$];
  int  total;
  int  bad;
  logic ld_hold;
  logic stray_pe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_ev(input logic [4:0] vec, input logic chk, input int base,
                         input int cnt, input logic accum, input logic bsy, input int gap);
    ev_t e;
    e.vec = vec; e.chk_pass = chk; e.base = 10'(base); e.cnt = 10'(cnt);
    e.accum = accum; e.busy = bsy; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic push_pass(input int base, input int cnt, input logic accum, input logic first);
    push_ev(V_LD, 1'b1, base, cnt, accum, 1'b1, first ? 0 : 2);
    push_ev(V_PE, 1'b1, base, cnt, accum, 1'b1, 2);
  endtask

  task automatic push_end();
    push_ev(V_DRAIN, 1'b0, 0, 0, 1'b0, 1'b1, 2);
    push_ev(V_DONE,  1'b0, 0, 0, 1'b0, 1'b0, 2);
  endtask

  // Passes of 4 channels: base 4*p, last pass takes the remainder.
  task automatic expect_tile(input int tic);
    for (int p = 0; p * 4 < tic; p++) begin
      push_pass(p * 4, (tic - p * 4 > 4) ? 4 : tic - p * 4, p != 0, p == 0);
    end
    push_end();
  endtask

  task automatic start_cfg(input logic [2:0] k, input logic [9:0] tic, input logic [5:0] h,
                           input logic [5:0] w, input logic [7:0] oc, input logic [2:0] st);
    @(posedge clk); #1;
    K = k; TOTAL_IC = tic; IMG_H = h; IMG_W = w; OC = oc; STRIDE = st;
    core_start = 1'b1;
    @(posedge clk); #1;
    core_start = 1'b0;
    K = 3'd2; TOTAL_IC = 10'd1; IMG_H = 6'd0; IMG_W = 6'd0; OC = 8'd0; STRIDE = 3'd0;
  endtask

  task automatic err_case(input logic [2:0] k, input logic [9:0] tic, input logic [5:0] h,
                          input logic [5:0] w, input logic [7:0] oc, input logic [2:0] st);
    push_ev(V_ERR, 1'b0, 0, 0, 1'b0, 1'b0, 0);
    start_cfg(k, tic, h, w, oc, st);
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string name);
    check({name, "_ctl"}, 32'({busy, ld_start, pe_start, drain_start, core_done, cfg_err, pe_accum}), 32'd0);
    check({name, "_base"}, 32'(pass_ic_base), 32'd0);
    check({name, "_cnt"}, 32'(pass_ic_cnt), 32'd0);
  endtask

  // Responder: each done answers the start seen in the previous cycle.
  initial begin
    logic ld_seen, pe_seen, dr_seen;
    ld_seen = 1'b0; pe_seen = 1'b0; dr_seen = 1'b0;
    ld_done = 1'b0; pe_done = 1'b0; drain_done = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (reset) begin
        ld_seen = 1'b0; pe_seen = 1'b0; dr_seen = 1'b0;
        ld_done = 1'b0; pe_done = 1'b0; drain_done = 1'b0;
      end else begin
        ld_done    = ld_seen || ld_hold;
        pe_done    = pe_seen || stray_pe;
        drain_done = dr_seen;
        ld_seen    = ld_start;
        pe_seen    = pe_start;
        dr_seen    = drain_start;
      end
    end
  end

  // Monitor: compare every pulse cycle against the head of the scoreboard.
  initial begin
    int cyc;
    int last_cyc;
    cyc = 0;
    last_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (|{ld_start, pe_start, drain_start, core_done, cfg_err}) begin
        if (exp_q.size() == 0) begin
          check("extra_event", 32'({ld_start, pe_start, drain_start, core_done, cfg_err}), 32'd0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("ev_pulses", 32'({ld_start, pe_start, drain_start, core_done, cfg_err}), 32'(e.vec));
          check("ev_busy", 32'(busy), 32'(e.busy));
          if (e.gap != 0) check("ev_gap", 32'(cyc - last_cyc), 32'(e.gap));
          if (e.chk_pass) begin
            check("ev_base", 32'(pass_ic_base), 32'(e.base));
            check("ev_cnt", 32'(pass_ic_cnt), 32'(e.cnt));
            check("ev_accum", 32'(pe_accum), 32'(e.accum));
          end
        end
        last_cyc = cyc;
      end
    end
  end

  initial begin
    int n;
    total = 0; bad = 0;
    reset = 1'b1; core_start = 1'b0; ld_hold = 1'b0; stray_pe = 1'b0;
    K = 3'd1; TOTAL_IC = 10'd1; IMG_H = 6'd1; IMG_W = 6'd1; OC = 8'd1; STRIDE = 3'd1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_state");
    reset = 1'b0;

    // Ten channels: three passes, bases 0/4/8, counts 4/4/2, accum 0/1/1.
    push_pass(0, 4, 1'b0, 1'b1);
    push_pass(4, 4, 1'b1, 1'b0);
    push_pass(8, 2, 1'b1, 1'b0);
    push_end();
    start_cfg(3'd3, 10'd10, 6'd8, 6'd8, 8'd16, 3'd1);
    wait_idle("tic10", 200);

    // Single pass of four channels.
    push_pass(0, 4, 1'b0, 1'b1);
    push_end();
    start_cfg(3'd1, 10'd4, 6'd16, 6'd16, 8'd8, 3'd2);
    wait_idle("tic4", 100);

    // Legal extremes with one channel.
    push_pass(0, 1, 1'b0, 1'b1);
    push_end();
    start_cfg(3'd3, 10'd1, 6'd32, 6'd32, 8'd64, 3'd2);
    wait_idle("tic1_max", 100);

    // Illegal configurations: error and done together, no load.
    err_case(3'd2, 10'd10, 6'd8, 6'd8, 8'd8, 3'd1);
    err_case(3'd0, 10'd10, 6'd8, 6'd8, 8'd8, 3'd1);
    err_case(3'd1, 10'd0, 6'd8, 6'd8, 8'd8, 3'd1);
    err_case(3'd1, 10'd513, 6'd8, 6'd8, 8'd8, 3'd1);
    err_case(3'd1, 10'd8, 6'd0, 6'd8, 8'd8, 3'd1);
    err_case(3'd1, 10'd8, 6'd8, 6'd33, 8'd8, 3'd1);
    err_case(3'd1, 10'd8, 6'd8, 6'd8, 8'd65, 3'd1);
    err_case(3'd1, 10'd8, 6'd8, 6'd8, 8'd0, 3'd1);
    err_case(3'd1, 10'd8, 6'd8, 6'd8, 8'd8, 3'd3);
    err_case(3'd1, 10'd8, 6'd8, 6'd8, 8'd8, 3'd0);
    wait_idle("cfg_err", 20);
    check("err_busy_idle", 32'(busy), 32'd0);

    // Seven channels; core_start and stray pe_done while in LOAD are ignored.
    push_pass(0, 4, 1'b0, 1'b1);
    push_pass(4, 3, 1'b1, 1'b0);
    push_end();
    start_cfg(3'd1, 10'd7, 6'd4, 6'd4, 8'd4, 3'd1);
    K = 3'd1; TOTAL_IC = 10'd4; IMG_H = 6'd4; IMG_W = 6'd4; OC = 8'd4; STRIDE = 3'd1;
    core_start = 1'b1; stray_pe = 1'b1;
    @(posedge clk); #1;
    core_start = 1'b0;
    @(posedge clk); #1;
    stray_pe = 1'b0;
    wait_idle("ignore_load", 100);

    // Reset during the compute of pass 2, then an immediate 512-channel run.
    expect_tile(16);
    start_cfg(3'd3, 10'd16, 6'd8, 6'd8, 8'd8, 3'd1);
    n = 0;
    while (!(pe_start && pass_ic_base == 10'd4) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_pass2", 32'(n < 50), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_zero("abort");
    exp_q.delete();
    reset = 1'b0;
    expect_tile(512);
    K = 3'd1; TOTAL_IC = 10'd512; IMG_H = 6'd32; IMG_W = 6'd32; OC = 8'd64; STRIDE = 3'd1;
    core_start = 1'b1;
    @(posedge clk); #1;
    core_start = 1'b0;
    TOTAL_IC = 10'd3;
    wait_idle("tic512", 1200);

    // ld_done held high: each LOAD is its start cycle plus one.
    ld_hold = 1'b1;
    expect_tile(8);
    start_cfg(3'd1, 10'd8, 6'd2, 6'd2, 8'd2, 3'd1);
    wait_idle("ld_hold", 100);
    ld_hold = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    check("final_pending", 32'(exp_q.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
